// File: rtl/lsq_mem_controller.sv
// In-order load/store queue feeding a single-port synchronous RAM and broadcasting loads on the CDB.
// Optional macro LSQ_BOUNDS_CHECK_EN adds o_mem_fault and suppresses out-of-window accesses.
module lsq_mem_controller #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned MEM_AW    = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_opcode,
  input  logic [5:0]        i_req_tag,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_data,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_cdb_valid,
  input  logic              i_cdb_grant,
  output logic [5:0]        o_cdb_tag,
  output logic [31:0]       o_cdb_data,
  output logic              o_store_done,
`ifdef LSQ_BOUNDS_CHECK_EN
  output logic              o_mem_fault,
`endif
  output logic              o_busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StLwait  = 2'd2;
  localparam logic [1:0] StBcast  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_d;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  logic [5:0]    r_cdb_tag;
  logic [31:0]   r_cdb_data;
  logic          r_fault;

  logic          r_q_load [DEPTH];
  logic [5:0]    r_q_tag  [DEPTH];
  logic [31:0]   r_q_addr [DEPTH];
  logic [31:0]   r_q_data [DEPTH];

  logic          w_op_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_head_load;
  logic [5:0]    w_head_tag;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_offset;
  logic          w_oow;
  logic          w_access_st;
  logic          w_access_ld;
  logic          w_unused_offset;

  assign o_req_ready = (r_count != FULL_COUNT);
  // No-op opcodes complete the handshake but never occupy an entry.
  assign w_op_valid  = (i_req_opcode == 2'b01) || (i_req_opcode == 2'b10);
  assign w_push      = i_req_valid && o_req_ready && w_op_valid;

  assign w_head_load = r_q_load[r_rd_ptr];
  assign w_head_tag  = r_q_tag[r_rd_ptr];
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];
  assign w_offset    = w_head_addr - BASE_ADDR;
  assign w_unused_offset = ^{w_offset[31:MEM_AW+2], w_offset[1:0]};

`ifdef LSQ_BOUNDS_CHECK_EN
  assign w_oow = (w_head_addr < BASE_ADDR) || ({1'b0, w_offset} >= (33'd4 << MEM_AW));
`else
  assign w_oow = 1'b0;
`endif

  assign w_access_st = (r_state == StAccess) && !w_head_load;
  assign w_access_ld = (r_state == StAccess) && w_head_load;
  // Stores leave the queue on their write cycle, loads once the read data is captured.
  assign w_pop       = w_access_st || (r_state == StLwait);
  assign w_count_d   = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_count_d != '0) w_state_d = StAccess;
      end
      StAccess: begin
        if (w_head_load) begin
          w_state_d = StLwait;
        end else if (w_count_d == '0) begin
          w_state_d = StIdle;
        end
      end
      StLwait: begin
        w_state_d = StBcast;
      end
      StBcast: begin
        if (i_cdb_grant) w_state_d = (w_count_d != '0) ? StAccess : StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_access_ld) begin
        r_cdb_tag <= w_head_tag;
        r_fault   <= w_oow;
      end
      if (r_state == StLwait) r_cdb_data <= r_fault ? '0 : i_mem_rdata;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_load[r_wr_ptr] <= (i_req_opcode == 2'b01);
      r_q_tag[r_wr_ptr]  <= i_req_tag;
      r_q_addr[r_wr_ptr] <= i_req_addr;
      r_q_data[r_wr_ptr] <= i_req_data;
    end
  end

  assign o_mem_we     = w_access_st && !w_oow;
  assign o_mem_re     = w_access_ld && !w_oow;
  assign o_mem_addr   = (r_state == StAccess) ? w_offset[MEM_AW+1:2] : '0;
  assign o_mem_wdata  = o_mem_we ? w_head_data : '0;
  assign o_store_done = w_access_st;
  assign o_cdb_valid  = (r_state == StBcast);
  assign o_cdb_tag    = o_cdb_valid ? r_cdb_tag : '0;
  assign o_cdb_data   = r_cdb_data;
  assign o_busy       = (r_count != '0) || (r_state != StIdle);

`ifdef LSQ_BOUNDS_CHECK_EN
  assign o_mem_fault  = (w_access_st && w_oow) || (o_cdb_valid && r_fault);
`endif

endmodule

// File: tb/tb_lsq_mem_controller.sv
// Bench for lsq_mem_controller: directed timing checks plus randomized ops scored against a
// queue/array reference model; a monitor compares memory-port and CDB traffic as it appears.
module tb_lsq_mem_controller;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned AW    = 10;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_opcode = 2'b00;
  logic [5:0]    req_tag = 6'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_data = 32'd0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata = 32'd0;
  logic          cdb_valid;
  logic          cdb_grant = 1'b0;
  logic [5:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          store_done;
  logic          busy;
`ifdef LSQ_BOUNDS_CHECK_EN
  logic          mem_fault;
`endif

  lsq_mem_controller #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE),
    .MEM_AW   (AW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_opcode(req_opcode),
    .i_req_tag   (req_tag),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_we    (mem_we),
    .o_mem_re    (mem_re),
    .i_mem_rdata (mem_rdata),
    .o_cdb_valid (cdb_valid),
    .i_cdb_grant (cdb_grant),
    .o_cdb_tag   (cdb_tag),
    .o_cdb_data  (cdb_data),
    .o_store_done(store_done),
`ifdef LSQ_BOUNDS_CHECK_EN
    .o_mem_fault (mem_fault),
`endif
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] word;
    logic [31:0]   data;
  } st_exp_t;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        fault;
  } cdb_exp_t;

  st_exp_t     exp_st[$];
  cdb_exp_t    exp_cdb[$];
  logic [31:0] model_mem [int unsigned];
  logic [31:0] ram [WORDS];
  bit          ram_vld [WORDS];
  int          checks = 0;
  int          failures = 0;
  int          n_cdb = 0;
  bit          mon_en = 1'b0;
  bit          stim_done = 1'b0;
  st_exp_t     mon_se;
  cdb_exp_t    mon_ce;

  function automatic logic [31:0] init_val(input int unsigned w);
    return (w * 32'h9E37_79B9) + 32'h1234_5678;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % WORDS;
  endfunction

  function automatic bit out_of_window(input logic [31:0] a);
`ifdef LSQ_BOUNDS_CHECK_EN
    return (a < BASE) || ((a - BASE) >= 32'(4 * WORDS));
`else
    return (a == a) ? 1'b0 : 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_rd(input int unsigned w);
    if (model_mem.exists(w)) return model_mem[w];
    return init_val(w);
  endfunction

  // Single-port RAM seen by the DUT; unwritten words read back their init pattern.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      ram_vld[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_val(32'(mem_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Program-order reference: each op's effect is fixed at the moment it is accepted.
  task automatic model_push(input logic [1:0] opc, input logic [5:0] tag,
                            input logic [31:0] addr, input logic [31:0] data);
    st_exp_t  se;
    cdb_exp_t ce;
    int unsigned w;
    w = word_of(addr);
    if (opc == 2'b10) begin
      se.wr   = !out_of_window(addr);
      se.word = AW'(w);
      se.data = data;
      exp_st.push_back(se);
      if (se.wr) model_mem[w] = data;
    end else if (opc == 2'b01) begin
      ce.tag   = tag;
      ce.fault = out_of_window(addr);
      ce.data  = ce.fault ? 32'd0 : model_rd(w);
      exp_cdb.push_back(ce);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the cycle after acceptance.
  task automatic push_op(input logic [1:0] opc, input logic [5:0] tag,
                         input logic [31:0] addr, input logic [31:0] data);
    int guard = 0;
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("push_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_opcode = opc;
    req_tag    = tag;
    req_addr   = addr;
    req_data   = data;
    model_push(opc, tag, addr, data);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_st.size() != 0 || exp_cdb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_stores", 32'(exp_st.size()), 32'd0);
    check("drain_loads", 32'(exp_cdb.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && mon_en) begin
      check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (store_done) begin
        if (exp_st.size() == 0) begin
          check("unexpected_store", 32'(store_done), 32'd0);
        end else begin
          mon_se = exp_st.pop_front();
          check("store_we", 32'(mem_we), 32'(mon_se.wr));
          if (mon_se.wr) begin
            check("store_addr", 32'(mem_addr), 32'(mon_se.word));
            check("store_data", mem_wdata, mon_se.data);
          end
`ifdef LSQ_BOUNDS_CHECK_EN
          check("store_fault", 32'(mem_fault), 32'(!mon_se.wr));
`endif
        end
      end else begin
        check("we_without_done", 32'(mem_we), 32'd0);
      end
      if (cdb_valid) begin
        if (exp_cdb.size() == 0) begin
          check("unexpected_cdb", 32'(cdb_valid), 32'd0);
        end else begin
          mon_ce = exp_cdb[0];
          check("cdb_tag", 32'(cdb_tag), 32'(mon_ce.tag));
          check("cdb_data", cdb_data, mon_ce.data);
`ifdef LSQ_BOUNDS_CHECK_EN
          check("cdb_fault", 32'(mem_fault), 32'(mon_ce.fault));
`endif
          if (cdb_grant) begin
            void'(exp_cdb.pop_front());
            n_cdb++;
          end
        end
      end else begin
        check("cdb_tag_idle", 32'(cdb_tag), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: time budget exceeded, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int guard;
    int r;
    logic [1:0]  opc;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    check("rst_store_done", 32'(store_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef LSQ_BOUNDS_CHECK_EN
    check("rst_fault", 32'(mem_fault), 32'd0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single store: write appears the cycle after enqueue.
    push_op(2'b10, 6'd5, 32'h1001_0008, 32'hDEAD_BEEF);
    check("st_lat_we", 32'(mem_we), 32'd1);
    check("st_lat_addr", 32'(mem_addr), 32'd2);
    check("st_lat_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_lat_done", 32'(store_done), 32'd1);
    @(negedge clk);
    check("st_busy_after", 32'(busy), 32'd0);

    // Load of the same word with the CDB always granting.
    cdb_grant = 1'b1;
    push_op(2'b01, 6'd7, 32'h1001_0008, 32'd0);
    check("ld_lat_re", 32'(mem_re), 32'd1);
    check("ld_lat_addr", 32'(mem_addr), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("ld_cdb_valid", 32'(cdb_valid), 32'd1);
    check("ld_cdb_tag", 32'(cdb_tag), 32'd7);
    check("ld_cdb_data", cdb_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("ld_cdb_valid_drop", 32'(cdb_valid), 32'd0);
    check("ld_cdb_tag_clear", 32'(cdb_tag), 32'd0);

    // Store/load interleave to one address: loads must see the preceding store.
    n0 = n_cdb;
    push_op(2'b10, 6'd10, BASE + 32'd20, 32'd1);
    push_op(2'b01, 6'd11, BASE + 32'd20, 32'd0);
    push_op(2'b10, 6'd12, BASE + 32'd20, 32'd2);
    push_op(2'b01, 6'd13, BASE + 32'd20, 32'd0);
    drain(200);
    check("order_cdb_count", 32'(n_cdb - n0), 32'd2);
    check("order_mem_final", model_rd(5), 32'd2);

    // Fill with the CDB stalled; the first load leaves the queue once in broadcast,
    // so DEPTH+1 loads are needed to reach full.
    cdb_grant = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push_op(2'b01, 6'(20 + i), BASE + 32'(4 * (i + 8)), 32'd0);
    check("fill_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(cdb_valid), 32'd1);
      check("stall_tag", 32'(cdb_tag), 32'd20);
      check("stall_data", cdb_data, init_val(8));
      check("stall_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    n0 = n_cdb;
    cdb_grant = 1'b1;
    drain(200);
    check("fill_drain_count", 32'(n_cdb - n0), 32'(DEPTH + 1));

`ifdef LSQ_BOUNDS_CHECK_EN
    push_op(2'b01, 6'd9, 32'h0000_0100, 32'd0);
    check("oow_ld_re", 32'(mem_re), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("oow_valid", 32'(cdb_valid), 32'd1);
    check("oow_tag", 32'(cdb_tag), 32'd9);
    check("oow_data", cdb_data, 32'd0);
    check("oow_fault", 32'(mem_fault), 32'd1);
    drain(50);
`endif

    // Randomized traffic with a randomly stalling CDB.
    n0 = n_cdb;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
          r = $urandom_range(0, 9);
          opc = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
          r = $urandom_range(0, 9);
          if (r < 7) a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
          else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
          else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
          else a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 7));
          push_op(opc, 6'($urandom_range(1, 63)), a, $urandom());
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          cdb_grant = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    join
    cdb_grant = 1'b1;
    drain(3000);
    check("random_some_loads", 32'(n_cdb > n0), 32'd1);

    // Reset in the middle of a broadcast with more work queued behind it.
    cdb_grant = 1'b0;
    push_op(2'b01, 6'd30, BASE + 32'd4, 32'd0);
    push_op(2'b01, 6'd31, BASE + 32'd8, 32'd0);
    push_op(2'b10, 6'd32, BASE + 32'd12, 32'h5555_AAAA);
    guard = 0;
    while (!cdb_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("pre_reset_bcast", 32'(cdb_valid), 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_st.delete();
    exp_cdb.delete();
    #1;
    check("mid_rst_valid", 32'(cdb_valid), 32'd0);
    check("mid_rst_tag", 32'(cdb_tag), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("in_rst_we", 32'(mem_we), 32'd0);
      check("in_rst_re", 32'(mem_re), 32'd0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_re", 32'(mem_re), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
